// File: rtl/load_unit.sv
// rtl/load_unit.sv - M-stage load unit: alignment/address-map check, one word read, byte/half extract and extend; optional bus timeout under LOAD_TIMEOUT_EN
module load_unit #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [2:0]  DEmod,
    input  logic        Req,
    output logic        rreq,
    output logic [31:0] raddr,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic [31:0] rd_out,
    output logic        done,
    output logic        busy,
    output logic [4:0]  ExcDE
);

    localparam logic [2:0] MOD_LW  = 3'b001;
    localparam logic [2:0] MOD_LH  = 3'b010;
    localparam logic [2:0] MOD_LHU = 3'b011;
    localparam logic [2:0] MOD_LB  = 3'b100;
    localparam logic [2:0] MOD_LBU = 3'b101;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_BUS  = 5'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t     state;
    logic [1:0] a_lo;
    logic [2:0] mod;
    logic       expired;

    function automatic logic is_load(input logic [2:0] m);
        return (m >= MOD_LW) && (m <= MOD_LBU);
    endfunction

    // Address error: misaligned, unmapped, or sub-word access to the word-only timer block
    function automatic logic adel(input logic [31:0] a, input logic [2:0] m);
        logic in_ram;
        logic in_tmr;
        logic in_dev;
        logic misal;
        in_ram = (a <= 32'h0000_2fff);
        in_tmr = ((a >= 32'h0000_7f00) && (a <= 32'h0000_7f0b)) ||
                 ((a >= 32'h0000_7f10) && (a <= 32'h0000_7f1b));
        in_dev = (a >= 32'h0000_7f20) && (a <= 32'h0000_7f23);
        misal  = ((m == MOD_LW) && (a[1:0] != 2'b00)) ||
                 (((m == MOD_LH) || (m == MOD_LHU)) && a[0]);
        return misal || !(in_ram || in_tmr || in_dev) || (in_tmr && (m != MOD_LW));
    endfunction

    // Pick the addressed lane out of the returned word and extend it to 32 bits
    function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] lo,
                                            input logic [2:0] m);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = lo[1] ? d[31:16] : d[15:0];
        case (lo)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        case (m)
            MOD_LW:  r = d;
            MOD_LH:  r = {{16{h[15]}}, h};
            MOD_LHU: r = {16'h0000, h};
            MOD_LB:  r = {{24{b[7]}}, b};
            MOD_LBU: r = {24'h000000, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

`ifdef LOAD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TW-1:0] tcnt;

    assign expired = (tcnt == TW'(TIMEOUT_CYC - 1));

    // Cycles spent waiting for a response; restarts on every entry into WAIT or DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt <= '0;
        end else if ((state != S_WAIT) && (state != S_DRAIN)) begin
            tcnt <= '0;
        end else if ((state == S_WAIT) && Req && !rvalid) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end
`else
    // Without the timeout feature a response is awaited indefinitely
    assign expired = (TIMEOUT_CYC < 0);
`endif

    // Load sequencing FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            rreq   <= 1'b0;
            raddr  <= 32'h0000_0000;
            rd_out <= 32'h0000_0000;
            done   <= 1'b0;
            busy   <= 1'b0;
            ExcDE  <= EXC_NONE;
            a_lo   <= 2'b00;
            mod    <= 3'b000;
        end else begin
            rreq <= 1'b0;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !Req && is_load(DEmod)) begin
                        a_lo  <= A[1:0];
                        mod   <= DEmod;
                        raddr <= {A[31:2], 2'b00};
                        busy  <= 1'b1;
                        if (adel(A, DEmod)) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            ExcDE  <= EXC_ADEL;
                            rd_out <= 32'h0000_0000;
                        end else begin
                            state <= S_REQ;
                            rreq  <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    // The read is already on the bus, so a flush must still absorb its response
                    state <= Req ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (rvalid) begin
                        if (Req) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            rd_out <= extract(rdata, a_lo, mod);
                            ExcDE  <= EXC_NONE;
                        end
                    end else if (Req) begin
                        state <= S_DRAIN;
                    end else if (expired) begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        rd_out <= 32'h0000_0000;
                        ExcDE  <= EXC_BUS;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                S_DRAIN: begin
                    if (rvalid || expired) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - table-driven and randomized self-checking bench for load_unit
module tb_load_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [2:0]  DEmod;
    logic        Req;
    logic        rreq;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic        rvalid;
    logic [31:0] rd_out;
    logic        done;
    logic        busy;
    logic [4:0]  ExcDE;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] hold_rd;
    logic [4:0]  hold_exc;

    always #5 clk = ~clk;

    load_unit #(.TIMEOUT_CYC(TO)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .DEmod  (DEmod),
        .Req    (Req),
        .rreq   (rreq),
        .raddr  (raddr),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rd_out (rd_out),
        .done   (done),
        .busy   (busy),
        .ExcDE  (ExcDE)
    );

    typedef struct {
        logic [31:0] a;
        logic [2:0]  m;
        logic [31:0] d;
        int          lat;
        logic [4:0]  exc;
        logic [31:0] rd;
    } vec_t;

    vec_t tbl[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_flags(input string name, input logic [2:0] exp);
        chk({name, " {rreq,done,busy}"}, {29'd0, rreq, done, busy}, {29'd0, exp});
    endtask

    // Reference: load semantics from the architectural rules, returns {exc, value}
    function automatic logic [36:0] ref_load(input logic [31:0] a, input logic [2:0] m,
                                             input logic [31:0] d);
        int          size;
        logic        sgn;
        logic        mapped;
        logic        timer;
        logic [31:0] v;
        size   = (m == 3'd1) ? 4 : ((m == 3'd2) || (m == 3'd3)) ? 2 : 1;
        sgn    = (m == 3'd2) || (m == 3'd4);
        timer  = (a >= 32'h7f00) && (a < 32'h7f1c) && !((a >= 32'h7f0c) && (a < 32'h7f10));
        mapped = (a < 32'h3000) || timer || ((a >= 32'h7f20) && (a < 32'h7f24));
        if ((a % size) != 0 || !mapped || (timer && size != 4))
            return {5'd4, 32'd0};
        v = d >> (8 * a[1:0]);
        if (size == 2) begin
            v = v & 32'h0000_ffff;
            if (sgn && v[15]) v = v | 32'hffff_0000;
        end else if (size == 1) begin
            v = v & 32'h0000_00ff;
            if (sgn && v[7]) v = v | 32'hffff_ff00;
        end
        return {5'd0, v};
    endfunction

    // One complete load with the response arriving lat cycles after rreq
    task automatic do_load(input logic [31:0] a, input logic [2:0] m, input logic [31:0] d,
                           input int lat, input logic [4:0] eexc, input logic [31:0] erd,
                           input string tag);
        A = a; DEmod = m; start = 1'b1;
        step();
        start = 1'b0;
        if (eexc == 5'd4) begin
            chk_flags({tag, " adel c1"}, 3'b011);
            chk({tag, " adel ExcDE"}, {27'd0, ExcDE}, {27'd0, eexc});
            chk({tag, " adel rd_out"}, rd_out, 32'd0);
            step();
            chk_flags({tag, " adel c2"}, 3'b000);
        end else begin
            chk_flags({tag, " c1"}, 3'b101);
            chk({tag, " raddr"}, raddr, {a[31:2], 2'b00});
            for (int k = 1; k <= lat; k++) begin
                step();
                chk_flags({tag, " wait"}, 3'b001);
                if (k == lat) begin
                    rvalid = 1'b1;
                    rdata  = d;
                end
            end
            step();
            rvalid = 1'b0;
            rdata  = $urandom;
            chk_flags({tag, " done"}, 3'b011);
            chk({tag, " rd_out"}, rd_out, erd);
            chk({tag, " ExcDE"}, {27'd0, ExcDE}, {27'd0, eexc});
            step();
            chk_flags({tag, " after"}, 3'b000);
            chk({tag, " rd_out held"}, rd_out, erd);
        end
        hold_rd  = erd;
        hold_exc = eexc;
    endtask

    initial begin
        logic [31:0] ra;
        logic [2:0]  rm;
        logic [31:0] rd;
        logic [36:0] r;
        int          seen_bad;

        tbl[0]  = '{32'h0000_0002, 3'd2, 32'h8001_1234, 3, 5'd0, 32'hffff_8001};
        tbl[1]  = '{32'h0000_0003, 3'd5, 32'hab00_0000, 1, 5'd0, 32'h0000_00ab};
        tbl[2]  = '{32'h0000_0002, 3'd1, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[3]  = '{32'h0000_7f04, 3'd4, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[4]  = '{32'h0000_3000, 3'd1, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[5]  = '{32'h0000_7f08, 3'd1, 32'h1234_5678, 2, 5'd0, 32'h1234_5678};
        tbl[6]  = '{32'h0000_0001, 3'd4, 32'h0000_8000, 1, 5'd0, 32'hffff_ff80};
        tbl[7]  = '{32'h0000_0000, 3'd3, 32'h1234_f00d, 2, 5'd0, 32'h0000_f00d};
        tbl[8]  = '{32'h0000_7f22, 3'd2, 32'h7fff_0000, 1, 5'd0, 32'h0000_7fff};
        tbl[9]  = '{32'h0000_7f0c, 3'd1, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[10] = '{32'h0000_2fff, 3'd5, 32'h8000_0000, 4, 5'd0, 32'h0000_0080};
        tbl[11] = '{32'h0000_0001, 3'd2, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[12] = '{32'h0000_2ffc, 3'd1, 32'hdead_beef, 1, 5'd0, 32'hdead_beef};
        tbl[13] = '{32'h0000_7f23, 3'd4, 32'h8000_0000, 2, 5'd0, 32'hffff_ff80};
        tbl[14] = '{32'h0000_7f1c, 3'd1, 32'h1111_1111, 1, 5'd4, 32'h0000_0000};
        tbl[15] = '{32'h0000_7f18, 3'd1, 32'h0000_0001, 1, 5'd0, 32'h0000_0001};

        reset = 1'b1; start = 1'b0; A = 32'd0; DEmod = 3'd0; Req = 1'b0;
        rdata = 32'd0; rvalid = 1'b0;
        step();
        step();
        chk_flags("reset", 3'b000);
        chk("reset raddr", raddr, 32'd0);
        chk("reset rd_out", rd_out, 32'd0);
        chk("reset ExcDE", {27'd0, ExcDE}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 16; i++)
            do_load(tbl[i].a, tbl[i].m, tbl[i].d, tbl[i].lat, tbl[i].exc, tbl[i].rd,
                    $sformatf("tbl%0d", i));

        // Randomized loads against the reference
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 5))
                0: ra = $urandom_range(0, 32'h2fff);
                1: ra = 32'h7f00 + $urandom_range(0, 11);
                2: ra = 32'h7f10 + $urandom_range(0, 11);
                3: ra = 32'h7f20 + $urandom_range(0, 3);
                4: ra = $urandom;
                default: ra = 32'h7f0c + 16 * $urandom_range(0, 1) + $urandom_range(0, 3);
            endcase
            rm = 3'($urandom_range(1, 5));
            rd = $urandom;
            r  = ref_load(ra, rm, rd);
            do_load(ra, rm, rd, $urandom_range(1, 4), r[36:32], r[31:0],
                    $sformatf("rnd%0d", i));
        end

        // Starts that must be ignored in IDLE
        for (int i = 0; i < 4; i++) begin
            A = 32'h0000_0010;
            Req   = (i == 0);
            DEmod = (i == 0) ? 3'd1 : (i == 1) ? 3'd0 : (i == 2) ? 3'd6 : 3'd7;
            start = 1'b1;
            step();
            start = 1'b0; Req = 1'b0;
            chk_flags($sformatf("ignored start %0d", i), 3'b000);
        end

        // Flush in WAIT, response 4 cycles later, start ignored while draining
        A = 32'h7f08; DEmod = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk_flags("flushW c1", 3'b101);
        step();
        Req = 1'b1;
        step();
        Req = 1'b0;
        chk_flags("flushW c3", 3'b001);
        A = 32'h0000_0000; DEmod = 3'd1; start = 1'b1;
        step();
        chk_flags("flushW c4", 3'b001);
        step();
        chk_flags("flushW c5", 3'b001);
        step();
        chk_flags("flushW c6", 3'b001);
        rvalid = 1'b1; rdata = 32'h5555_aaaa;
        step();
        rvalid = 1'b0; start = 1'b0;
        chk_flags("flushW c7", 3'b000);
        chk("flushW rd_out", rd_out, hold_rd);
        chk("flushW ExcDE", {27'd0, ExcDE}, {27'd0, hold_exc});
        step();
        chk_flags("flushW c8", 3'b000);

        // Flush in REQ
        A = 32'h0000_0100; DEmod = 3'd1; start = 1'b1;
        step();
        start = 1'b0; Req = 1'b1;
        step();
        Req = 1'b0;
        chk_flags("flushR c2", 3'b001);
        rvalid = 1'b1; rdata = 32'h0bad_0bad;
        step();
        rvalid = 1'b0;
        chk_flags("flushR c3", 3'b000);
        chk("flushR rd_out", rd_out, hold_rd);

        // Flush together with the response in WAIT
        A = 32'h0000_0104; DEmod = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        Req = 1'b1; rvalid = 1'b1; rdata = 32'h0bad_f00d;
        step();
        Req = 1'b0; rvalid = 1'b0;
        chk_flags("flushV c3", 3'b000);
        chk("flushV rd_out", rd_out, hold_rd);

        // Flush arriving in DONE does not suppress the pulse
        A = 32'h0000_0001; DEmod = 3'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rvalid = 1'b1; rdata = 32'h0000_5a00;
        step();
        rvalid = 1'b0; Req = 1'b1;
        chk_flags("flushD done", 3'b011);
        chk("flushD rd_out", rd_out, 32'h0000_005a);
        step();
        Req = 1'b0;
        chk_flags("flushD after", 3'b000);

        // Reset during WAIT, then a stale response
        do_load(32'h7f20, 3'd1, 32'hcafe_f00d, 1, 5'd0, 32'hcafe_f00d, "pre-reset");
        A = 32'h0000_0004; DEmod = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_flags("rstW", 3'b000);
        chk("rstW rd_out", rd_out, 32'd0);
        chk("rstW raddr", raddr, 32'd0);
        chk("rstW ExcDE", {27'd0, ExcDE}, 32'd0);
        rvalid = 1'b1; rdata = 32'hffff_ffff;
        step();
        rvalid = 1'b0;
        chk_flags("rstW stale", 3'b000);
        chk("rstW stale rd_out", rd_out, 32'd0);
        do_load(32'h0000_0008, 3'd1, 32'h1122_3344, 2, 5'd0, 32'h1122_3344, "post-reset");

        // Response that never comes
        A = 32'h0000_0010; DEmod = 3'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk_flags("noresp c1", 3'b101);
        seen_bad = 0;
`ifdef LOAD_TIMEOUT_EN
        for (int k = 1; k <= TO; k++) begin
            step();
            if ({rreq, done, busy} != 3'b001) seen_bad++;
        end
        chk("timeout wait cycles", seen_bad, 0);
        step();
        chk_flags("timeout done", 3'b011);
        chk("timeout ExcDE", {27'd0, ExcDE}, 32'd7);
        chk("timeout rd_out", rd_out, 32'd0);
        step();
        chk_flags("timeout after", 3'b000);
`else
        for (int k = 1; k <= 3 * TO; k++) begin
            step();
            if ({rreq, done, busy} != 3'b001) seen_bad++;
        end
        chk("no-timeout busy held", seen_bad, 0);
        chk("no-timeout ExcDE", {27'd0, ExcDE}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_flags("no-timeout reset", 3'b000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
